// File: rtl/cdb_arbiter.sv
// cdb_arbiter: three producer FIFOs (ALU/LSB/ROB) share one registered CDB broadcast.
// Define CDB_ARB_RR_EN for round-robin grant; otherwise fixed priority ROB > ALU > LSB.
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic              alu_valid,
    input  logic [DATA_W-1:0] alu_value,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic              lsb_valid,
    input  logic [DATA_W-1:0] lsb_value,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic              rob_valid,
    input  logic [DATA_W-1:0] rob_value,
    input  logic [TAG_W-1:0]  rob_tag,
    output logic              alu_ready,
    output logic              lsb_ready,
    output logic              rob_ready,
    output logic              cdb_valid,
    output logic [DATA_W-1:0] cdb_value,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [1:0]        cdb_src
);
    localparam int EW = DATA_W + TAG_W;
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

    logic [EW-1:0]     mem_q [3][QDEPTH];
    logic [EW-1:0]     mem_d [3][QDEPTH];
    logic [PW-1:0]     head_q [3];
    logic [PW-1:0]     head_d [3];
    logic [PW-1:0]     tail_q [3];
    logic [PW-1:0]     tail_d [3];
    logic [PW:0]       cnt_q [3];
    logic [PW:0]       cnt_d [3];
    logic              cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [1:0]        cdb_src_q, cdb_src_d;
    logic [EW-1:0]     din [3];
    logic [2:0]        valid, nonempty, ready, push, pop;
    logic [1:0]        gnt;
    logic              en, any;

    assign din[0] = {alu_tag, alu_value};
    assign din[1] = {lsb_tag, lsb_value};
    assign din[2] = {rob_tag, rob_value};
    assign valid  = {rob_valid, lsb_valid, alu_valid};
    assign en     = rdy & ~jump_wrong;

    always_comb begin
        nonempty = '0;
        ready    = '0;
        for (int i = 0; i < 3; i++) begin
            nonempty[i] = cnt_q[i] != '0;
            ready[i]    = rst & en & (cnt_q[i] != FULL);
        end
    end

    assign any  = |nonempty;
    assign push = valid & ready;
    assign pop  = {3{en & any}} & {gnt == 2'd2, gnt == 2'd1, gnt == 2'd0};

    assign alu_ready = ready[0];
    assign lsb_ready = ready[1];
    assign rob_ready = ready[2];

`ifdef CDB_ARB_RR_EN
    // rr_q holds the first source to consider, i.e. one past the last grant
    logic [1:0] rr_q, rr_d, c1, c2;
    assign c1   = rr_q == 2'd2 ? 2'd0 : rr_q + 2'd1;
    assign c2   = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
    assign gnt  = nonempty[rr_q] ? rr_q : nonempty[c1] ? c1 : c2;
    assign rr_d = jump_wrong ? 2'd0 : (en & any) ? (gnt == 2'd2 ? 2'd0 : gnt + 2'd1) : rr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_q <= 2'd0;
        else
            rr_q <= rr_d;
    end
`else
    assign gnt = nonempty[2] ? 2'd2 : nonempty[0] ? 2'd0 : 2'd1;
`endif

    always_comb begin
        mem_d       = mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        cdb_valid_d = en & any;
        cdb_value_d = cdb_value_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem_d[i][tail_q[i]] = din[i];
                tail_d[i]           = tail_q[i] + 1'b1;
            end
            if (pop[i])
                head_d[i] = head_q[i] + 1'b1;
            cnt_d[i] = cnt_q[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
        end
        if (en & any) begin
            {cdb_tag_d, cdb_value_d} = mem_q[gnt][head_q[gnt]];
            cdb_src_d                = gnt;
        end
        if (jump_wrong) begin
            for (int i = 0; i < 3; i++) begin
                head_d[i] = '0;
                tail_d[i] = '0;
                cnt_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '{default: '0};
            tail_q      <= '{default: '0};
            cnt_q       <= '{default: '0};
            cdb_valid_q <= 1'b0;
            cdb_value_q <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= 2'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_value_q <= cdb_value_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    // storage needs no reset: counts gate every read
    always_ff @(posedge clk)
        mem_q <= mem_d;

    assign cdb_valid = cdb_valid_q;
    assign cdb_value = cdb_value_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter; follows CDB_ARB_RR_EN like the design.
module tb_cdb_arbiter;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int QD = 2;
    localparam int EW = DW + TW;

    typedef logic [EW-1:0] ent_t;
    typedef struct packed {
        logic [1:0] src;
        ent_t       e;
    } bc_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b0;
    logic          jump_wrong = 1'b0;
    logic          alu_valid = 1'b0, lsb_valid = 1'b0, rob_valid = 1'b0;
    logic [DW-1:0] alu_value = '0, lsb_value = '0, rob_value = '0;
    logic [TW-1:0] alu_tag = '0, lsb_tag = '0, rob_tag = '0;
    logic          alu_ready, lsb_ready, rob_ready;
    logic          cdb_valid;
    logic [DW-1:0] cdb_value;
    logic [TW-1:0] cdb_tag;
    logic [1:0]    cdb_src;

    int         n_cmp = 0;
    int         n_err = 0;
    ent_t       stim_q [3][$];
    ent_t       mq [3][$];
    bc_t        exp_q [$];
    logic [6:0] log_q [$];
    logic       m_v = 1'b0;
    bc_t        m_last = '0;
`ifdef CDB_ARB_RR_EN
    int         m_rr = 0;
`endif

    always #5 clk = ~clk;

    cdb_arbiter #(.DATA_W(DW), .TAG_W(TW), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .alu_valid(alu_valid), .alu_value(alu_value), .alu_tag(alu_tag),
        .lsb_valid(lsb_valid), .lsb_value(lsb_value), .lsb_tag(lsb_tag),
        .rob_valid(rob_valid), .rob_value(rob_value), .rob_tag(rob_tag),
        .alu_ready(alu_ready), .lsb_ready(lsb_ready), .rob_ready(rob_ready),
        .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_tag(cdb_tag), .cdb_src(cdb_src)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick();
`ifdef CDB_ARB_RR_EN
        for (int k = 0; k < 3; k++)
            if (mq[(m_rr + k) % 3].size() != 0) return (m_rr + k) % 3;
`else
        if (mq[2].size() != 0) return 2;
        if (mq[0].size() != 0) return 0;
        if (mq[1].size() != 0) return 1;
`endif
        return -1;
    endfunction

    task automatic drive(input logic r, input logic jw);
        rdy        = r;
        jump_wrong = jw;
        alu_valid  = stim_q[0].size() != 0;
        lsb_valid  = stim_q[1].size() != 0;
        rob_valid  = stim_q[2].size() != 0;
        if (alu_valid) {alu_tag, alu_value} = stim_q[0][0];
        if (lsb_valid) {lsb_tag, lsb_value} = stim_q[1][0];
        if (rob_valid) {rob_tag, rob_value} = stim_q[2][0];
    endtask

    // One clock: drive, predict the edge with the reference model, then compare after it
    task automatic step(input logic r, input logic jw);
        logic [2:0] rd;
        int         g;
        bc_t        bc;
        drive(r, jw);
        #1;
        for (int i = 0; i < 3; i++)
            rd[i] = r && !jw && mq[i].size() < QD;
        check("ready", {rob_ready, lsb_ready, alu_ready}, rd);
        m_v = 1'b0;
        if (jw) begin
            for (int i = 0; i < 3; i++) begin
                mq[i].delete();
                if (stim_q[i].size() != 0) void'(stim_q[i].pop_front());
            end
`ifdef CDB_ARB_RR_EN
            m_rr = 0;
`endif
        end else if (r) begin
            g = pick();
            if (g >= 0) begin
                m_v    = 1'b1;
                m_last = {2'(g), mq[g].pop_front()};
                exp_q.push_back(m_last);
`ifdef CDB_ARB_RR_EN
                m_rr = (g + 1) % 3;
`endif
            end
            for (int i = 0; i < 3; i++)
                if (rd[i] && stim_q[i].size() != 0) mq[i].push_back(stim_q[i].pop_front());
        end
        @(posedge clk);
        #1;
        check("cdb_valid", cdb_valid, m_v);
        if (cdb_valid) begin
            check("exp_q_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                bc = exp_q.pop_front();
                check("bc_src", cdb_src, bc.src);
                check("bc_tag", cdb_tag, bc.e[EW-1:DW]);
                check("bc_value", cdb_value, bc.e[DW-1:0]);
            end
            log_q.push_back({cdb_src, cdb_tag});
        end else begin
            check("hold", {cdb_src, cdb_tag, cdb_value}, m_last);
        end
    endtask

    task automatic reset_mid();
        #2 rst = 1'b0;
        #1;
        check("rst_valid", cdb_valid, 1'b0);
        check("rst_bus", {cdb_src, cdb_tag, cdb_value}, '0);
        check("rst_ready", {rob_ready, lsb_ready, alu_ready}, 3'b000);
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            stim_q[i].delete();
        end
        exp_q.delete();
        m_last = '0;
        m_v    = 1'b0;
`ifdef CDB_ARB_RR_EN
        m_rr = 0;
`endif
        drive(1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_valid", cdb_valid, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        rdy = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("init_valid", cdb_valid, 1'b0);
        check("init_bus", {cdb_src, cdb_tag, cdb_value}, '0);
        check("init_ready", {rob_ready, lsb_ready, alu_ready}, 3'b000);
        @(posedge clk);
        #1 rst = 1'b1;

        // single producer, back-to-back
        log_q.delete();
        stim_q[0].push_back({5'd3, 32'h11});
        stim_q[0].push_back({5'd4, 32'h22});
        stim_q[0].push_back({5'd5, 32'h33});
        repeat (6) step(1'b1, 1'b0);
        check("single_n", log_q.size(), 3);
        for (int i = 0; i < 3 && i < log_q.size(); i++)
            check("single_bc", log_q[i], {2'd0, 5'(3 + i)});

        // all three producers contending
        log_q.delete();
        for (int i = 0; i < 6; i++) begin
            stim_q[0].push_back({5'(8 + i), 32'($urandom)});
            stim_q[1].push_back({5'(16 + i), 32'($urandom)});
            stim_q[2].push_back({5'(24 + i), 32'($urandom)});
        end
        repeat (20) step(1'b1, 1'b0);
        check("arb_n", log_q.size(), 18);
        for (int i = 0; i < 6 && i < log_q.size(); i++)
`ifdef CDB_ARB_RR_EN
            check("arb_src", log_q[i][6:5], 2'(i % 3));
`else
            check("arb_src", log_q[i][6:5], 2'd2);
`endif

        // freeze with one LSB entry pending
        log_q.delete();
        stim_q[1].push_back({5'd7, 32'h77});
        step(1'b1, 1'b0);
        stim_q[1].push_back({5'd9, 32'h99});
        repeat (3) step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        check("frz_n", log_q.size(), 2);
        if (log_q.size() != 0) check("frz_first", log_q[0], {2'd1, 5'd7});

        // flush with one entry per FIFO and a ROB result offered in the flush cycle
        log_q.delete();
        stim_q[0].push_back({5'd1, 32'hA1});
        stim_q[1].push_back({5'd2, 32'hB2});
        stim_q[2].push_back({5'd3, 32'hC3});
        step(1'b1, 1'b0);
        stim_q[2].push_back({5'd31, 32'hDEAD});
        step(1'b1, 1'b1);
        stim_q[0].push_back({5'd6, 32'hE6});
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0);
        check("flush_n", log_q.size(), 0);

        // wrap-around through the LSB FIFO with stalls
        log_q.delete();
        for (int i = 0; i < 5; i++)
            stim_q[1].push_back({5'(i), 32'($urandom)});
        for (int i = 0; i < 16; i++)
            step(i % 3 != 2, 1'b0);
        check("wrap_n", log_q.size(), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++)
            check("wrap_bc", log_q[i], {2'd1, 5'(i)});

        // asynchronous reset mid-operation
        log_q.delete();
        for (int i = 0; i < 3; i++) begin
            stim_q[0].push_back({5'(10 + i), 32'($urandom)});
            stim_q[2].push_back({5'(20 + i), 32'($urandom)});
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        reset_mid();
        log_q.delete();
        repeat (4) step(1'b1, 1'b0);
        check("post_rst_n", log_q.size(), 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
